// File: rtl/wave_analyzer_pkg.sv
// wave_analyzer shared types and helpers.
// Holds the FSM state encoding and the saturating threshold helpers.
package wave_analyzer_pkg;

  typedef enum logic [1:0] {
    ACQ_LOW  = 2'd0,
    ACQ_HIGH = 2'd1,
    RUN_LOW  = 2'd2,
    RUN_HIGH = 2'd3
  } wa_state_e;

  localparam logic [7:0] THRESH_INIT = 8'd128;

  function automatic logic [7:0] thr_hi(
    input logic [7:0] t,
    input logic [7:0] h
  );
    logic [8:0] s;
    s = {1'b0, t} + {1'b0, h};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] thr_lo(
    input logic [7:0] t,
    input logic [7:0] h
  );
    return (t < h) ? 8'h00 : (t - h);
  endfunction

endpackage

// File: rtl/wave_analyzer_if.sv
// wave_analyzer sample/measurement bundle.
// master drives samples, slave is the analyzer.
interface wave_analyzer_if #(
  parameter int PW = 16
);
  logic          ENB;
  logic [7:0]    SAMPLE;
  logic [PW-1:0] PERIOD;
  logic [7:0]    PEAK_MAX;
  logic [7:0]    PEAK_MIN;
  logic [7:0]    AMPLITUDE;
  logic          MEAS_STB;
  logic          VALID;
  logic          TIMEOUT;

  modport master (
    output ENB, SAMPLE,
    input  PERIOD, PEAK_MAX, PEAK_MIN,
    input  AMPLITUDE, MEAS_STB, VALID, TIMEOUT
  );

  modport slave (
    input  ENB, SAMPLE,
    output PERIOD, PEAK_MAX, PEAK_MIN,
    output AMPLITUDE, MEAS_STB, VALID, TIMEOUT
  );
endinterface

// File: rtl/wave_crossing_detector.sv
// Hysteresis comparator around the current threshold.
// o_arm: sample below LO, o_cross: sample at or above HI.
module wave_crossing_detector #(
  parameter logic [7:0] HYST = 8'd8
) (
  input  logic [7:0] i_thresh,
  input  logic [7:0] i_sample,
  output logic       o_arm,
  output logic       o_cross
);
  import wave_analyzer_pkg::*;

  logic [7:0] w_hi;
  logic [7:0] w_lo;

  assign w_hi    = thr_hi(i_thresh, HYST);
  assign w_lo    = thr_lo(i_thresh, HYST);
  assign o_arm   = (i_sample < w_lo);
  assign o_cross = (i_sample >= w_hi);

endmodule

// File: rtl/wave_analyzer.sv
// Waveform period / peak analyzer with adaptive threshold.
// Measures one full cycle between consecutive rising crossings.
module wave_analyzer #(
  parameter int         PW          = 16,
  parameter logic [7:0] HYST        = 8'd8,
  parameter logic [7:0] THRESH_INIT =
    wave_analyzer_pkg::THRESH_INIT
) (
  input  logic           CLK,
  input  logic           RST,
  wave_analyzer_if.slave bus
);
  import wave_analyzer_pkg::*;

  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0] CNT_ONE =
    {{(PW-1){1'b0}}, 1'b1};

  wa_state_e     r_state;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic [7:0]    r_run_max;
  logic [7:0]    r_run_min;
  logic [7:0]    r_max;
  logic [7:0]    r_min;
  logic [7:0]    r_amp;
  logic [7:0]    r_thresh;
  logic          r_stb;
  logic          r_valid;
  logic          r_timeout;

  logic          w_arm;
  logic          w_cross;
  logic          w_to;
  logic [8:0]    w_sum;
  logic [7:0]    w_nmax;
  logic [7:0]    w_nmin;
  logic [7:0]    w_s;

  assign w_s = bus.SAMPLE;

  wave_crossing_detector #(
    .HYST (HYST)
  ) u_det (
    .i_thresh (r_thresh),
    .i_sample (w_s),
    .o_arm    (w_arm),
    .o_cross  (w_cross)
  );

  assign w_sum  = {1'b0, r_run_max}
                + {1'b0, r_run_min} + 9'd1;
  assign w_nmax = (w_s > r_run_max) ? w_s : r_run_max;
  assign w_nmin = (w_s < r_run_min) ? w_s : r_run_min;

  // In RUN_LOW nothing is armed, so no sample there is a crossing.
  assign w_to = (r_cnt == CNT_MAX) &&
    ((r_state == RUN_LOW) ||
     ((r_state == RUN_HIGH) && !w_cross));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ACQ_LOW;
      r_cnt     <= '0;
      r_period  <= '0;
      r_run_max <= 8'd0;
      r_run_min <= 8'd0;
      r_max     <= 8'd0;
      r_min     <= 8'd0;
      r_amp     <= 8'd0;
      r_thresh  <= THRESH_INIT;
      r_stb     <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (bus.ENB) begin
        if (w_to) begin
          r_state   <= ACQ_LOW;
          r_cnt     <= '0;
          r_valid   <= 1'b0;
          r_timeout <= 1'b1;
          r_thresh  <= THRESH_INIT;
        end else begin
          unique case (r_state)
            ACQ_LOW: begin
              if (w_arm) r_state <= ACQ_HIGH;
            end
            ACQ_HIGH: begin
              if (w_cross) begin
                r_state   <= RUN_LOW;
                r_cnt     <= CNT_ONE;
                r_run_max <= w_s;
                r_run_min <= w_s;
              end
            end
            RUN_LOW: begin
              r_cnt     <= r_cnt + CNT_ONE;
              r_run_max <= w_nmax;
              r_run_min <= w_nmin;
              if (w_arm) r_state <= RUN_HIGH;
            end
            RUN_HIGH: begin
              if (w_cross) begin
                r_state   <= RUN_LOW;
                r_period  <= r_cnt;
                r_max     <= r_run_max;
                r_min     <= r_run_min;
                r_amp     <= r_run_max - r_run_min;
                r_stb     <= 1'b1;
                r_valid   <= 1'b1;
                r_timeout <= 1'b0;
                r_thresh  <= w_sum[8:1];
                r_cnt     <= CNT_ONE;
                r_run_max <= w_s;
                r_run_min <= w_s;
              end else begin
                r_cnt     <= r_cnt + CNT_ONE;
                r_run_max <= w_nmax;
                r_run_min <= w_nmin;
              end
            end
            default: r_state <= ACQ_LOW;
          endcase
        end
      end
    end
  end

  assign bus.PERIOD    = r_period;
  assign bus.PEAK_MAX  = r_max;
  assign bus.PEAK_MIN  = r_min;
  assign bus.AMPLITUDE = r_amp;
  assign bus.MEAS_STB  = r_stb;
  assign bus.VALID     = r_valid;
  assign bus.TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed bench for wave_analyzer (PW=10 to keep timeouts short).
// Expected values are hand-derived from the waveform shapes.
module tb_wave_analyzer;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nstb;
  int   first;
  int   last;

  wave_analyzer_if #(.PW(10)) bus ();

  wave_analyzer #(
    .PW          (10),
    .HYST        (8'd8),
    .THRESH_INIT (8'd128)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] s);
    @(negedge clk);
    bus.ENB    = en;
    bus.SAMPLE = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tri_at(input int n);
    int p;
    int v;
    p = n % 510;
    v = (p <= 255) ? p : (510 - p);
    return v[7:0];
  endfunction

  function automatic logic [7:0] sq(
    input int i, input logic [7:0] lo, input logic [7:0] hi
  );
    return ((i / 50) % 2 == 1) ? hi : lo;
  endfunction

  task automatic track(input int idx);
    if (bus.MEAS_STB) begin
      nstb++;
      if (first < 0) first = idx;
      last = idx;
    end
  endtask

  task automatic clr();
    nstb  = 0;
    first = -1;
    last  = -1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ENB    = 1'b0;
    bus.SAMPLE = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", 32'(bus.PERIOD), 0);
    check("rst_max", 32'(bus.PEAK_MAX), 0);
    check("rst_min", 32'(bus.PEAK_MIN), 0);
    check("rst_amp", 32'(bus.AMPLITUDE), 0);
    check("rst_stb", 32'(bus.MEAS_STB), 0);
    check("rst_valid", 32'(bus.VALID), 0);
    check("rst_tmo", 32'(bus.TIMEOUT), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // triangle 0..255..0, crossings at n=136, 646, 1156, 1666
    clr();
    for (int n = 0; n <= 1666; n++) begin
      step(1'b1, tri_at(n));
      track(n);
      if (n == 136) check("tri_novalid", 32'(bus.VALID), 0);
    end
    check("tri_nstb", nstb, 3);
    check("tri_first", first, 646);
    check("tri_last", last, 1666);
    check("tri_period", 32'(bus.PERIOD), 510);
    check("tri_max", 32'(bus.PEAK_MAX), 255);
    check("tri_min", 32'(bus.PEAK_MIN), 0);
    check("tri_amp", 32'(bus.AMPLITUDE), 255);
    check("tri_valid", 32'(bus.VALID), 1);
    check("tri_tmo", 32'(bus.TIMEOUT), 0);
    step(1'b1, tri_at(1667));
    check("tri_stb_drop", 32'(bus.MEAS_STB), 0);

    // square 20/230, 50 per level, five cycles
    clr();
    for (int i = 0; i < 500; i++) begin
      step(1'b1, sq(i, 8'd20, 8'd230));
      track(i);
    end
    check("sq_nstb", nstb, 5);
    check("sq_period", 32'(bus.PERIOD), 100);
    check("sq_max", 32'(bus.PEAK_MAX), 230);
    check("sq_min", 32'(bus.PEAK_MIN), 20);
    check("sq_amp", 32'(bus.AMPLITUDE), 210);
    check("sq_thresh", 32'(dut.r_thresh), 125);

    // constant 128: cnt goes 50 -> 1023, then times out
    for (int i = 0; i < 973; i++) step(1'b1, 8'd128);
    check("to_pre_tmo", 32'(bus.TIMEOUT), 0);
    check("to_pre_valid", 32'(bus.VALID), 1);
    step(1'b1, 8'd128);
    check("to_tmo", 32'(bus.TIMEOUT), 1);
    check("to_valid", 32'(bus.VALID), 0);
    check("to_hold_per", 32'(bus.PERIOD), 100);
    check("to_hold_amp", 32'(bus.AMPLITUDE), 210);
    check("to_thresh", 32'(dut.r_thresh), 128);

    // triangle again clears TIMEOUT at its first latch
    for (int n = 0; n <= 646; n++) begin
      step(1'b1, tri_at(n));
      if (n == 645) check("rec_pre_tmo", 32'(bus.TIMEOUT), 1);
    end
    check("rec_tmo", 32'(bus.TIMEOUT), 0);
    check("rec_valid", 32'(bus.VALID), 1);
    check("rec_stb", 32'(bus.MEAS_STB), 1);
    check("rec_period", 32'(bus.PERIOD), 510);

    // 124/132 never leaves the hysteresis band
    clr();
    for (int i = 0; i < 1022; i++) begin
      step(1'b1, sq(i, 8'd124, 8'd132));
      track(i);
    end
    check("band_pre_tmo", 32'(bus.TIMEOUT), 0);
    check("band_nstb", nstb, 0);
    step(1'b1, sq(1022, 8'd124, 8'd132));
    check("band_tmo", 32'(bus.TIMEOUT), 1);

    // 0/255 with ENB every other cycle; gap samples are junk
    clr();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, sq(i, 8'd0, 8'd255));
      track(i);
      step(1'b0, ~sq(i, 8'd0, 8'd255));
      if (last == i) check("gap_stb", 32'(bus.MEAS_STB), 0);
    end
    check("gap_nstb", nstb, 2);
    check("gap_period", 32'(bus.PERIOD), 100);
    check("gap_amp", 32'(bus.AMPLITUDE), 255);
    check("gap_valid", 32'(bus.VALID), 1);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) step(1'b1, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", 32'(bus.PERIOD), 0);
    check("arst_max", 32'(bus.PEAK_MAX), 0);
    check("arst_amp", 32'(bus.AMPLITUDE), 0);
    check("arst_valid", 32'(bus.VALID), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    for (int i = 0; i < 400; i++) begin
      step(1'b1, sq(i, 8'd0, 8'd255));
      track(i);
    end
    check("post_first", first, 150);
    check("post_nstb", nstb, 3);
    check("post_period", 32'(bus.PERIOD), 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_analyzer.md
# wave_analyzer

Measurement block for the digital function generator's 8-bit waveform output, the receiving end of the waveform path. It samples the generated wave on a strobe, detects rising threshold crossings with hysteresis, and reports per-cycle period (in samples), peak maximum, peak minimum and peak-to-peak amplitude. It sits after the waveform generator's output mux, so the bench and on-board self-test can check frequency and amplitude selection without an external scope.

## Interface
- PW, 16: period counter width in samples.
- HYST, 8: hysteresis half-width in LSBs around the threshold.
- THRESH_INIT, 128: threshold after reset or timeout.

- CLK  in  1  system clock (generator clock domain).
- RST  in  1  asynchronous, active-low reset.
- ENB  in  1  sample strobe; one sample accepted per cycle with ENB=1.
- SAMPLE  in  8  unsigned waveform sample.
- PERIOD  out  PW  samples between the last two rising crossings.
- PEAK_MAX  out  8  largest sample in the last measured cycle.
- PEAK_MIN  out  8  smallest sample in the last measured cycle.
- AMPLITUDE  out  8  PEAK_MAX − PEAK_MIN.
- MEAS_STB  out  1  one-cycle pulse when the measurement outputs update.
- VALID  out  1  outputs hold a complete measurement.
- TIMEOUT  out  1  sticky; the period counter saturated without a crossing.

## Operation
- Thresholds: HI = min(THRESH+HYST, 255) and LO = max(THRESH−HYST, 0), both saturating. A rising crossing is an accepted sample ≥ HI while armed. Accepting a sample < LO arms the detector.
- FSM states: ACQ_LOW, ACQ_HIGH, RUN_LOW, RUN_HIGH. All transitions occur only on accepted samples (ENB=1).
  - ACQ_LOW → ACQ_HIGH on a sample < LO.
  - ACQ_HIGH → RUN_LOW on a crossing, which is the first crossing. At that edge: cnt←1, run_max and run_min ← sample.
  - RUN_LOW → RUN_HIGH on a sample < LO.
  - RUN_HIGH → RUN_LOW on a crossing. At that edge: PERIOD←cnt, PEAK_MAX←run_max, PEAK_MIN←run_min, AMPLITUDE←run_max−run_min, MEAS_STB=1, VALID←1, TIMEOUT←0, THRESH←(run_max+run_min+1)>>1 using a 9-bit sum. Then cnt←1 and run_max/run_min←sample, so the crossing sample belongs to the new cycle.
- In RUN states on a non-crossing sample: cnt←cnt+1, run_max←max, run_min←min.
- Timeout: if cnt = 2^PW−1 and the sample is not a crossing, go to ACQ_LOW with VALID←0, TIMEOUT←1 and THRESH←THRESH_INIT. The measurement outputs keep their last values.
- A sample that is both < LO and ≥ HI is impossible because HYST ≥ 1. HYST=0 is illegal.
- When ENB=0, all state and outputs hold and MEAS_STB=0.

## Timing
- Reset (RST=0, asynchronous) forces:
  - State ACQ_LOW.
  - PERIOD, PEAK_MAX, PEAK_MIN and AMPLITUDE to 0.
  - MEAS_STB, VALID and TIMEOUT to 0.
  - THRESH to THRESH_INIT, cnt to 0.
- Reset asserted mid-measurement discards the partial cycle. Deassertion is synchronized by the integrator; the first accepted sample is the first ENB=1 edge after release.
- All outputs are registered. The crossing sample is accepted at edge k; the outputs and MEAS_STB are visible after edge k and MEAS_STB drops after edge k+1 (single-cycle pulse even if ENB stays high).
- Crossings exactly N accepted samples apart yield PERIOD=N. ENB gaps do not count.
- A new THRESH applies from the sample after the latching edge.

## Structure
- A shared package `wave_analyzer_pkg` holds:
  - the state encoding (2-bit enum for ACQ_LOW/ACQ_HIGH/RUN_LOW/RUN_HIGH);
  - THRESH_INIT;
  - the saturating HI/LO helper functions.
- One sub-module, `wave_crossing_detector`, is natural: THRESH/HYST in, arm and crossing flags out. The FSM, counter and peak trackers stay in the top.
- Target size is roughly 200 lines of RTL.

## Test plan
- Triangle ramp 0→255→0 (510 samples/cycle), ENB=1 → from the second crossing onward: PERIOD=510, PEAK_MAX=255, PEAK_MIN=0, AMPLITUDE=255, MEAS_STB once per 510 samples, VALID=1.
- Square wave 20/230 with 50 samples per level → PERIOD=100, AMPLITUDE=210, THRESH converges to 125.
- Constant 128 with PW=10 → VALID stays 0 and TIMEOUT=1 after reaching the cnt=1023 limit; applying the triangle afterwards clears TIMEOUT at the next latch.
- Square wave 124/132 (swing below 2·HYST) → no crossing ever, so TIMEOUT follows.
- Square 0/255 with ENB toggled every other cycle → PERIOD counts only accepted samples, same value as with continuous ENB.
- RST pulsed low mid-cycle after VALID=1 → all outputs 0 immediately; the first MEAS_STB occurs only after two full crossings post-release.
